// File: rtl/ser2par_frame_ctrl_if.sv
// Serial-in / parallel-out bundle for ser2par_frame_ctrl.
// master drives the serial line and consumer ready; slave is the framing controller.
interface ser2par_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  din;
  logic                  din_valid;
  logic                  sof;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  overrun;
  logic                  clr_overrun;
  logic                  busy;
  logic                  parity_err;

  modport master (
    output din, din_valid, sof, dout_ready, clr_overrun,
    input  dout, dout_valid, overrun, busy, parity_err
  );

  modport slave (
    input  din, din_valid, sof, dout_ready, clr_overrun,
    output dout, dout_valid, overrun, busy, parity_err
  );
endinterface

// File: rtl/ser2par_frame_ctrl.sv
// Framing deserializer: hunts for sof, shifts DATA_WIDTH bits MSB first, holds the word for a valid/ready consumer.
// Latency: dout_valid rises 1 cycle after the last bit (parity bit when SER2PAR_PARITY_EN is defined).
// Backpressure: one holding register; a word completing while it is full and not drained is dropped and sets sticky overrun.
module ser2par_frame_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  ser2par_frame_ctrl_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef SER2PAR_PARITY_EN
  typedef enum logic [1:0] {HUNT, COLLECT, PARITY} state_t;
`else
  typedef enum logic {HUNT, COLLECT} state_t;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;
  logic                  perr_q, perr_d;

  logic [DATA_WIDTH-1:0] word_c;
  logic                  perr_c;
  logic                  done_c;
  logic                  free_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_c  = {shift_q[DATA_WIDTH-2:0], bus.din};
    perr_c  = 1'b0;
    done_c  = 1'b0;
    if (bus.din_valid) begin
      if (bus.sof) begin
        // sof always restarts the word, even mid-word, without flagging an error
        shift_d = {{(DATA_WIDTH-1){1'b0}}, bus.din};
        cnt_d   = CW'(1);
        state_d = COLLECT;
      end else begin
        unique case (state_q)
          COLLECT: begin
            shift_d = word_c;
            if (cnt_q == LAST) begin
              cnt_d = '0;
`ifdef SER2PAR_PARITY_EN
              state_d = PARITY;
`else
              state_d = HUNT;
              done_c  = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SER2PAR_PARITY_EN
          PARITY: begin
            word_c  = shift_q;
            perr_c  = (^shift_q) ^ bus.din;
            done_c  = 1'b1;
            state_d = HUNT;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    free_c = !dvld_q || bus.dout_ready;
    dout_d = dout_q;
    dvld_d = dvld_q;
    perr_d = perr_q;
    ovr_d  = ovr_q;
    busy_d = (state_d != HUNT);
    if (done_c && free_c) begin
      dout_d = word_c;
      perr_d = perr_c;
      dvld_d = 1'b1;
    end else if (dvld_q && bus.dout_ready) begin
      dvld_d = 1'b0;
    end
    if (done_c && !free_c) begin
      ovr_d = 1'b1;
    end else if (bus.clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dvld_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;
  assign bus.parity_err = perr_q;

endmodule
